mem_miss_scoreboard: RTL and testbench
======================================

Name: mem_miss_scoreboard

Overview:
Parametrised successor to the memory stage's fixed 4-entry load-miss shift register. It tracks up to DEPTH outstanding load misses by tag, so loads can complete out of order, and handles WAW on the same destination register. It provides dependency stalls for NUM_SRC source operands and a drain indication for branch/jump resolution. The scoreboard sits between the memory stage (allocate on load miss) and the MMIO/cache return path (complete by tag), and drives a registered writeback-injection port toward WB.

Parameters:
DEPTH, 4, number of outstanding miss entries (>=2)
NUM_SRC, 2, number of source-register dependency ports
XLEN, 32, data width
REG_W, 5, register index width
TAG_W, $clog2(DEPTH), entry tag width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
alloc_valid  in  1  load miss to record this cycle
alloc_rd  in  REG_W  destination register of the miss
alloc_ready  out  1  entry free; alloc accepted when alloc_valid && alloc_ready
alloc_tag  out  TAG_W  tag assigned to the accepted alloc (combinational)
done_valid  in  1  miss data returned
done_tag  in  TAG_W  tag of the returning miss
done_data  in  XLEN  returned load data
wb_valid  out  1  registered writeback injection
wb_rd  out  REG_W  writeback register
wb_data  out  XLEN  writeback data
src_rd  in  NUM_SRC*REG_W  packed source register indices from execute
src_hit  out  NUM_SRC  per-source pending hit (combinational)
dep_stall  out  1  OR of src_hit
drained  out  1  no valid entries
count  out  $clog2(DEPTH+1)  valid entry count
err_spurious  out  1  one-cycle registered pulse on a done for an invalid tag

Behaviour:
- **Reset** (rst_n low at a clk edge):
  - All entries are invalid.
  - wb_valid, wb_rd, wb_data, err_spurious and count are 0; drained is 1.
  - Reset mid-operation discards all pending misses; no writeback is produced afterward.
- **Entry state:** valid, rd[REG_W], youngest.
- **Allocation:**
  - alloc_ready = (count < DEPTH), computed from registered state only. There is no same-cycle reuse of an entry freed by done.
  - alloc_tag is the lowest-index invalid entry.
  - On acceptance, the entry becomes valid with rd = alloc_rd and youngest = 1.
  - Any other valid entry with the same rd has youngest cleared at the same edge.
- **Completion:**
  - done_valid with a valid done_tag frees that entry at the next edge.
  - At that edge: wb_valid = 1, wb_rd = rd, wb_data = done_data, but only if the entry is youngest after same-cycle allocation is applied, and rd != 0. Otherwise wb_valid = 0 (superseded write suppressed).
  - wb_valid is held for exactly one cycle per completion.
  - done_valid for an invalid tag: state unchanged, wb_valid = 0, err_spurious = 1 for the next cycle.
- **Simultaneous alloc + done:** both are applied at the same edge.
  - count = count + 1 - 1.
  - If alloc_rd equals the completing entry's rd, the completing write is suppressed.
- **Dependency check:**
  - src_hit[i] = 1 when src_rd[i] != 0 and there is any valid youngest entry with rd == src_rd[i].
  - Computed from registered state only: an entry completing this cycle still hits. The stall releases the cycle wb_valid presents the value, and WB forwarding supplies it.
  - dep_stall = |src_hit.
- **x0 loads:** alloc_rd = 0 still consumes an entry (needed for ordering/drain), never hits, and never produces wb_valid.
- **Drain:**
  - drained = (count == 0).
  - The memory stage holds branch/jal resolution until drained is 1. The scoreboard itself takes no flush input; committed misses are never cancelled.
- **count:** updated every edge as count + accepted_alloc - valid_done. It never exceeds DEPTH and never underflows.
- **Latency:** alloc is visible in src_hit/count the cycle after acceptance; done to wb_valid is 1 cycle.

Test Plan:
1. **Reset:** hold rst_n = 0 for 2 cycles mid-traffic, then release -> count = 0, drained = 1, wb_valid = 0; a later done_tag = 0 gives err_spurious = 1 for one cycle.
2. **Out-of-order completion:** alloc rd = 5, 6, 7 (tags 0, 1, 2), then done tag 2 data 0x33, then tag 0 data 0x11 -> wb (7, 0x33) then (5, 0x11), each one cycle after its done; src_rd = 6 still hits; count = 1.
3. **Full:** DEPTH = 4; four allocs -> alloc_ready = 0, count = 4. In the same cycle, alloc_valid = 1 and done tag 1 -> alloc not accepted. Next cycle alloc_ready = 1 and alloc_tag = 1.
4. **WAW:** alloc rd = 9 (tag 0), then alloc rd = 9 (tag 1); done tag 0 -> wb_valid = 0 and src_rd = 9 still hits; done tag 1 data 0xAB -> wb (9, 0xAB), then src_hit clears.
5. **Same-cycle alloc + done:** tag 0 with rd = 3 pending; alloc rd = 3 and done tag 0 in the same cycle -> no writeback, new tag 1 with youngest = 1, count unchanged.
6. **x0 and drain:** alloc rd = 0 -> src_rd = 0 gives no hit, drained = 0; done -> wb_valid = 0, drained = 1 the next cycle.

Source files
------------

// File: rtl/mem_miss_scoreboard.sv
// ============================================================================
//  Module      : mem_miss_scoreboard
//  Description : Tag-indexed outstanding load-miss tracker with out-of-order
//                completion, WAW suppression, source dependency stalls and a
//                drain indication.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_miss_scoreboard #(
    parameter int DEPTH   = 4,
    parameter int NUM_SRC = 2,
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    localparam int TAG_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    input  logic [REG_W-1:0]         alloc_rd,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic                     done_valid,
    input  logic [TAG_W-1:0]         done_tag,
    input  logic [XLEN-1:0]          done_data,
    output logic                     wb_valid,
    output logic [REG_W-1:0]         wb_rd,
    output logic [XLEN-1:0]          wb_data,
    input  logic [NUM_SRC*REG_W-1:0] src_rd,
    output logic [NUM_SRC-1:0]       src_hit,
    output logic                     dep_stall,
    output logic                     drained,
    output logic [CNT_W-1:0]         count,
    output logic                     err_spurious
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_young;
    logic [REG_W-1:0] r_rd [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_wb_valid;
    logic [REG_W-1:0] r_wb_rd;
    logic [XLEN-1:0]  r_wb_data;
    logic             r_err;

    logic             w_alloc_ready;
    logic             w_alloc_fire;
    logic [TAG_W-1:0] w_alloc_tag;
    logic             w_done_hit;
    logic             w_done_ok;
    logic [REG_W-1:0] w_done_rd;
    logic             w_done_young;
    logic             w_wb_fire;
    logic [NUM_SRC-1:0] w_src_hit;

    // Freed entries only become allocatable after the edge that frees them.
    assign w_alloc_ready = (r_count < CNT_W'(DEPTH));
    assign w_alloc_fire  = alloc_valid && w_alloc_ready;

    always_comb begin
        w_alloc_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin
        w_done_hit   = 1'b0;
        w_done_rd    = '0;
        w_done_young = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (done_tag == TAG_W'(i) && r_valid[i]) begin
                w_done_hit   = 1'b1;
                w_done_rd    = r_rd[i];
                w_done_young = r_young[i];
            end
        end
    end

    assign w_done_ok = done_valid && w_done_hit;

    // A same-cycle alloc to the same rd supersedes the completing write.
    assign w_wb_fire = w_done_ok && w_done_young && (w_done_rd != '0)
                     && !(w_alloc_fire && (alloc_rd == w_done_rd));

    always_comb begin
        w_src_hit = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (src_rd[s*REG_W +: REG_W] != '0 && r_valid[e] && r_young[e]
                    && r_rd[e] == src_rd[s*REG_W +: REG_W]) begin
                    w_src_hit[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_young    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i] <= '0;
            end
            r_count    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && w_alloc_tag == TAG_W'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_young[i] <= 1'b1;
                    r_rd[i]    <= alloc_rd;
                end else if (w_done_ok && done_tag == TAG_W'(i)) begin
                    r_valid[i] <= 1'b0;
                    r_young[i] <= 1'b0;
                end else if (w_alloc_fire && r_valid[i] && r_rd[i] == alloc_rd) begin
                    r_young[i] <= 1'b0;
                end
            end
            r_count    <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_done_ok);
            r_wb_valid <= w_wb_fire;
            if (w_wb_fire) begin
                r_wb_rd   <= w_done_rd;
                r_wb_data <= done_data;
            end
            r_err      <= done_valid && !w_done_hit;
        end
    end

    assign alloc_ready  = w_alloc_ready;
    assign alloc_tag    = w_alloc_tag;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign src_hit      = w_src_hit;
    assign dep_stall    = |w_src_hit;
    assign drained      = (r_count == '0);
    assign count        = r_count;
    assign err_spurious = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_miss_scoreboard.sv
// ============================================================================
//  Module      : tb_mem_miss_scoreboard
//  Description : Directed scenarios plus randomized traffic against a
//                sequence-number reference model of the miss scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_miss_scoreboard;

    localparam int DEPTH   = 4;
    localparam int NUM_SRC = 2;
    localparam int XLEN    = 32;
    localparam int REG_W   = 5;
    localparam int TAG_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     alloc_valid;
    logic [REG_W-1:0]         alloc_rd;
    logic                     alloc_ready;
    logic [TAG_W-1:0]         alloc_tag;
    logic                     done_valid;
    logic [TAG_W-1:0]         done_tag;
    logic [XLEN-1:0]          done_data;
    logic                     wb_valid;
    logic [REG_W-1:0]         wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic [NUM_SRC*REG_W-1:0] src_rd;
    logic [NUM_SRC-1:0]       src_hit;
    logic                     dep_stall;
    logic                     drained;
    logic [CNT_W-1:0]         count;
    logic                     err_spurious;

    mem_miss_scoreboard #(
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN),
        .REG_W   (REG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .done_valid   (done_valid),
        .done_tag     (done_tag),
        .done_data    (done_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .src_rd       (src_rd),
        .src_hit      (src_hit),
        .dep_stall    (dep_stall),
        .drained      (drained),
        .count        (count),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an entry is youngest iff it holds the most recent
    // allocation ever made to its destination register.
    bit               m_valid [DEPTH];
    logic [REG_W-1:0] m_rd    [DEPTH];
    int               m_seq   [DEPTH];
    int               last_seq [32];
    int               seq_ctr = 0;
    bit               e_wbv   = 1'b0;
    logic [REG_W-1:0] e_wb_rd = '0;
    logic [XLEN-1:0]  e_wb_data = '0;
    bit               e_err   = 1'b0;
    bit               e_rst0  = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [REG_W-1:0] r);
        bit h = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (r != 0 && m_valid[j] && m_rd[j] == r && m_seq[j] == last_seq[r]) h = 1'b1;
        end
        return h;
    endfunction

    task automatic step(input bit rn, input bit av, input int ard, input bit dv,
                        input int dt, input int dd, input int s0, input int s1);
        int  cnt;
        int  ftag;
        bit  acc;
        bit  dok;
        bit  yng;
        bit  h0;
        bit  h1;
        rst_n       = rn;
        alloc_valid = av;
        alloc_rd    = REG_W'(ard);
        done_valid  = dv;
        done_tag    = TAG_W'(dt);
        done_data   = XLEN'(dd);
        src_rd      = {REG_W'(s1), REG_W'(s0)};
        #1;
        cnt  = 0;
        ftag = -1;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (m_valid[j]) cnt++;
            else ftag = j;
        end
        check("count", 64'(count), 64'(cnt));
        check("drained", 64'(drained), 64'(cnt == 0));
        check("alloc_ready", 64'(alloc_ready), 64'(cnt < DEPTH));
        if (cnt < DEPTH) check("alloc_tag", 64'(alloc_tag), 64'(ftag));
        h0 = m_hit(REG_W'(s0));
        h1 = m_hit(REG_W'(s1));
        check("src_hit", 64'(src_hit), 64'({h1, h0}));
        check("dep_stall", 64'(dep_stall), 64'(h0 | h1));
        check("wb_valid", 64'(wb_valid), 64'(e_wbv));
        if (e_wbv || e_rst0) begin
            check("wb_rd", 64'(wb_rd), 64'(e_wb_rd));
            check("wb_data", 64'(wb_data), 64'(e_wb_data));
        end
        check("err_spurious", 64'(err_spurious), 64'(e_err));

        if (!rn) begin
            for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
            e_wbv = 1'b0; e_wb_rd = '0; e_wb_data = '0; e_err = 1'b0; e_rst0 = 1'b1;
        end else begin
            acc = av && (cnt < DEPTH);
            dok = dv && m_valid[dt];
            yng = dok && (m_seq[dt] == last_seq[m_rd[dt]]) && !(acc && m_rd[dt] == REG_W'(ard));
            e_wbv  = yng && (m_rd[dt] != 0);
            e_err  = dv && !dok;
            e_rst0 = 1'b0;
            if (e_wbv) begin
                e_wb_rd   = m_rd[dt];
                e_wb_data = XLEN'(dd);
            end
            if (dok) m_valid[dt] = 1'b0;
            if (acc) begin
                seq_ctr++;
                m_valid[ftag]  = 1'b1;
                m_rd[ftag]     = REG_W'(ard);
                m_seq[ftag]    = seq_ctr;
                last_seq[ard]  = seq_ctr;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alloc(input int rd, input int s0);
        step(1'b1, 1'b1, rd, 1'b0, 0, 0, s0, 0);
    endtask

    task automatic done(input int t, input int d, input int s0);
        step(1'b1, 1'b0, 0, 1'b1, t, d, s0, 0);
    endtask

    task automatic idle(input int s0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, s0, 0);
    endtask

    initial begin
        for (int j = 0; j < DEPTH; j++) begin
            m_valid[j] = 1'b0; m_rd[j] = '0; m_seq[j] = 0;
        end
        for (int r = 0; r < 32; r++) last_seq[r] = -1;
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; done_valid = 1'b0;
        done_tag = '0; done_data = '0; src_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset mid-traffic
        alloc(4, 0);
        alloc(5, 0);
        step(1'b0, 1'b1, 6, 1'b1, 0, 32'h77, 4, 5);
        step(1'b0, 1'b1, 7, 1'b0, 0, 0, 4, 5);
        check("rst_count", 64'(count), 64'd0);
        check("rst_drained", 64'(drained), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        done(0, 32'h99, 4);
        check("rst_spurious", 64'(err_spurious), 64'd1);
        idle(0);
        check("spurious_pulse", 64'(err_spurious), 64'd0);

        // Out-of-order completion
        alloc(5, 0); alloc(6, 0); alloc(7, 0);
        done(2, 32'h33, 0);
        check("ooo_wb1", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd7, 32'h33}));
        done(0, 32'h11, 6);
        check("ooo_wb2", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd5, 32'h11}));
        check("ooo_hit6", 64'(src_hit[0]), 64'd1);
        check("ooo_count", 64'(count), 64'd1);
        done(1, 32'h22, 0);
        idle(0);

        // Full
        alloc(1, 0); alloc(2, 0); alloc(3, 0); alloc(4, 0);
        check("full_ready", 64'(alloc_ready), 64'd0);
        step(1'b1, 1'b1, 8, 1'b1, 1, 32'h44, 0, 0);
        check("full_count", 64'(count), 64'd3);
        check("full_ready2", 64'(alloc_ready), 64'd1);
        check("full_tag", 64'(alloc_tag), 64'd1);
        done(0, 1, 0); done(2, 2, 0); done(3, 3, 0);
        idle(0);

        // WAW
        alloc(9, 0); alloc(9, 0);
        done(0, 32'h5A, 9);
        check("waw_suppress", 64'(wb_valid), 64'd0);
        check("waw_hit", 64'(src_hit[0]), 64'd1);
        done(1, 32'hAB, 9);
        check("waw_wb", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd9, 32'hAB}));
        check("waw_clear", 64'(src_hit[0]), 64'd0);

        // Same-cycle alloc + done on same rd
        alloc(3, 0);
        step(1'b1, 1'b1, 3, 1'b1, 0, 32'h66, 3, 0);
        check("sc_nowb", 64'(wb_valid), 64'd0);
        check("sc_count", 64'(count), 64'd1);
        done(1, 32'h55, 0);
        check("sc_wb", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd3, 32'h55}));

        // x0 load and drain
        alloc(0, 0);
        idle(0);
        check("x0_nohit", 64'(src_hit), 64'd0);
        check("x0_drained", 64'(drained), 64'd0);
        done(0, 32'h12, 0);
        check("x0_nowb", 64'(wb_valid), 64'd0);
        check("x0_drain", 64'(drained), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 4), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
